point_zbt_writer: RTL and testbench
===================================

Name: point_zbt_writer

Overview:
Upstream feeder for the ZBT write port in the scanner datapath. It accepts a stream of reconstructed 3D points (x, y, z; 10 bits each) over a valid/ready handshake and buffers them in a small FIFO. Each point is packed into a 36-bit ZBT word and written to consecutive addresses starting at BASE_ADDR, one write per granted ZBT write slot. Operation is framed by frame_start/frame_end pulses; the block reports the number of points stored and any overflow.

Parameters:
BASE_ADDR, 0, first ZBT address written in each frame
MAX_POINTS, 307200, maximum points stored per frame; BASE_ADDR+MAX_POINTS-1 must be <= 2^19-1 (no address wrap)
FIFO_DEPTH, 4, point FIFO entries (power of 2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse: begin a new frame
frame_end  in  1  one-cycle pulse: no more points this frame
pt_valid  in  1  point on pt_x/pt_y/pt_z is valid
pt_ready  out  1  block accepts a point this cycle
pt_x  in  10  x coordinate
pt_y  in  10  y coordinate
pt_z  in  10  z coordinate
wr_slot  in  1  ZBT write slot available this cycle (from the ZBT arbiter)
write_addr  out  19  ZBT write address
write_data  out  36  ZBT write data {6'b0, x, y, z}
write_en  out  1  write strobe, valid for write_addr/write_data
point_count  out  19  writes issued this frame
busy  out  1  high in CAPTURE or DRAIN
overflow  out  1  sticky: a point was offered after capacity was exhausted
done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (sync, highest priority): state IDLE, FIFO emptied, all outputs 0 (write_addr=0, write_data=0, write_en=0, pt_ready=0, point_count=0, busy=0, overflow=0, done=0). Any in-flight write is dropped.
- States: IDLE, CAPTURE, DRAIN, DONE.
- IDLE: pt_ready=0. frame_start -> CAPTURE. On entry, the address counter is loaded with BASE_ADDR; point_count, accepted count and overflow are cleared. frame_end is ignored. If frame_start and frame_end coincide, frame_start wins and frame_end is ignored.
- CAPTURE:
  - pt_ready = FIFO not full AND accepted < MAX_POINTS. pt_ready is combinational from registered state.
  - A point is accepted on pt_valid&&pt_ready and pushed as {6'b0,pt_x,pt_y,pt_z}.
  - pt_valid while accepted==MAX_POINTS sets overflow; the point is not accepted.
  - frame_end -> DRAIN. frame_start is ignored. A point accepted in the same cycle as frame_end is kept.
- Write issue (CAPTURE and DRAIN): when wr_slot=1 and the FIFO is not empty, pop the head. Next cycle: write_en=1, write_addr=address counter, write_data=popped word. Then address counter++ and point_count++.
  - write_en is registered and is 0 in every other cycle.
  - write_addr/write_data hold their last values when write_en=0.
- Latency: point accepted at cycle N with wr_slot high from N+1 -> write_en at N+2 (minimum).
- FIFO: push when full is impossible (pt_ready=0). Simultaneous push and pop is allowed. Order is preserved.
- DRAIN: pt_ready=0. Stays in DRAIN until the FIFO is empty and no write is pending, then -> DONE.
- DONE: done=1 for exactly one cycle, busy=0, -> IDLE. point_count and overflow hold until the next frame_start.

Decomposition:
- Shared package zbt_pkg:
  - ZBT_ADDR_W=19, ZBT_DATA_W=36, COORD_W=10
  - state encoding for IDLE/CAPTURE/DRAIN/DONE
  - pack_point(x,y,z) function returning {6'b0,x,y,z}
- Sub-module point_fifo: synchronous FIFO parameterised by width/depth, with full/empty flags.

Test Plan:
1. Assert reset 3 cycles -> all outputs 0 and state IDLE. pt_valid=1 in IDLE -> pt_ready stays 0 and no write occurs.
2. frame_start, point (100,100,1020), wr_slot=1 -> 2 cycles after acceptance write_en=1, write_addr=0, write_data=36'h0064193FC, point_count=1.
3. wr_slot=0 for 10 cycles with 6 points offered -> exactly 4 accepted and pt_ready=0. wr_slot=1 afterwards -> 4 writes to addresses 0..3 in input order, then the remaining 2 points are accepted and written to 4,5.
4. MAX_POINTS=8, offer 10 points with wr_slot=1 -> 8 writes to addresses 0..7, overflow=1, point_count=8, pt_ready=0 after the 8th accept.
5. 3 points queued (wr_slot=0), then frame_end, then wr_slot=1 -> 3 writes, done pulses exactly once, busy falls, state IDLE. A following frame_start restarts at BASE_ADDR with point_count=0 and overflow=0.
6. Reset asserted during DRAIN with 2 entries queued -> next cycle write_en=0, FIFO empty, state IDLE. A new frame_start writes its first point to BASE_ADDR.

Source files
------------

// File: rtl/zbt_pkg.sv
// Shared definitions for the ZBT point writer: bus widths, writer states,
// and the packing of a 3D point into one ZBT word.
package zbt_pkg;
  localparam int ZBT_ADDR_W = 19;
  localparam int ZBT_DATA_W = 36;
  localparam int COORD_W    = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } wr_state_t;

  function automatic logic [ZBT_DATA_W-1:0] pack_point(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input logic [COORD_W-1:0] z
  );
    return {6'b0, x, y, z};
  endfunction
endpackage

// File: rtl/point_fifo.sv
// Small synchronous FIFO with a registered read port; pop_data presents the
// popped word the cycle after pop and holds it until the next pop.
module point_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = rd_data_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      rd_data_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_reg  <= rd_ptr_reg + (AW+1)'(1);
        rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
      end
    end
  end
endmodule

// File: rtl/point_zbt_writer.sv
// Buffers reconstructed 3D points and writes them as packed words to
// consecutive ZBT addresses, one per granted write slot, framed by start/end.
module point_zbt_writer
  import zbt_pkg::*;
#(
  parameter int BASE_ADDR  = 0,
  parameter int MAX_POINTS = 307200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic                  pt_valid,
  output logic                  pt_ready,
  input  logic [COORD_W-1:0]    pt_x,
  input  logic [COORD_W-1:0]    pt_y,
  input  logic [COORD_W-1:0]    pt_z,
  input  logic                  wr_slot,
  output logic [ZBT_ADDR_W-1:0] write_addr,
  output logic [ZBT_DATA_W-1:0] write_data,
  output logic                  write_en,
  output logic [ZBT_ADDR_W-1:0] point_count,
  output logic                  busy,
  output logic                  overflow,
  output logic                  done
);
  // One extra bit so a full-address-space MAX_POINTS still compares correctly.
  localparam int                    CNT_W   = ZBT_ADDR_W + 1;
  localparam logic [CNT_W-1:0]      MAX_CNT = CNT_W'(MAX_POINTS);
  localparam logic [ZBT_ADDR_W-1:0] BASE    = ZBT_ADDR_W'(BASE_ADDR);

  wr_state_t               state_reg;
  wr_state_t               state_next;
  logic [ZBT_ADDR_W-1:0]   addr_cnt_reg;
  logic [ZBT_ADDR_W-1:0]   write_addr_reg;
  logic [ZBT_ADDR_W-1:0]   point_count_reg;
  logic [CNT_W-1:0]        accepted_reg;
  logic                    overflow_reg;
  logic                    write_en_reg;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic [ZBT_DATA_W-1:0]   fifo_pop_data;
  logic                    capturing;
  logic                    has_room;
  logic                    frame_begin;
  logic                    push;
  logic                    pop;

  assign capturing   = (state_reg == ST_CAPTURE);
  assign has_room    = (accepted_reg < MAX_CNT);
  assign frame_begin = (state_reg == ST_IDLE) && frame_start;
  assign push        = pt_valid && pt_ready;
  assign pop         = ((state_reg == ST_CAPTURE) || (state_reg == ST_DRAIN)) &&
                       wr_slot && !fifo_empty;

  point_fifo #(
    .WIDTH (ZBT_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (pack_point(pt_x, pt_y, pt_z)),
    .pop       (pop),
    .pop_data  (fifo_pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pt_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (frame_start) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        pt_ready = !fifo_full && has_room;
        busy     = 1'b1;
        if (frame_end) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // A write strobing this cycle still counts as pending.
        if (fifo_empty && !write_en_reg) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_cnt_reg    <= '0;
      write_addr_reg  <= '0;
      point_count_reg <= '0;
      accepted_reg    <= '0;
      overflow_reg    <= 1'b0;
      write_en_reg    <= 1'b0;
    end else begin
      write_en_reg <= pop;
      if (frame_begin) begin
        addr_cnt_reg    <= BASE;
        point_count_reg <= '0;
        accepted_reg    <= '0;
        overflow_reg    <= 1'b0;
      end else begin
        if (pop) begin
          write_addr_reg  <= addr_cnt_reg;
          addr_cnt_reg    <= addr_cnt_reg + ZBT_ADDR_W'(1);
          point_count_reg <= point_count_reg + ZBT_ADDR_W'(1);
        end
        if (push) begin
          accepted_reg <= accepted_reg + CNT_W'(1);
        end
        if (capturing && pt_valid && !has_room) begin
          overflow_reg <= 1'b1;
        end
      end
    end
  end

  assign write_en    = write_en_reg;
  assign write_addr  = write_addr_reg;
  assign write_data  = fifo_pop_data;
  assign point_count = point_count_reg;
  assign overflow    = overflow_reg;
endmodule

// File: tb/tb_point_zbt_writer.sv
// Self-checking bench: directed frame scenarios plus random traffic, all
// compared every cycle against a queue-based model of the point writer.
module tb_point_zbt_writer;
  localparam int BASE  = 0;
  localparam int MAXP  = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        frame_end = 1'b0;
  logic        pt_valid = 1'b0;
  logic        wr_slot = 1'b0;
  logic [9:0]  pt_x = '0, pt_y = '0, pt_z = '0;
  logic        pt_ready, write_en, busy, overflow, done;
  logic [18:0] write_addr, point_count;
  logic [35:0] write_data;

  always #5 clk = ~clk;

  point_zbt_writer #(.BASE_ADDR(BASE), .MAX_POINTS(MAXP), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z),
    .wr_slot(wr_slot), .write_addr(write_addr), .write_data(write_data),
    .write_en(write_en), .point_count(point_count), .busy(busy),
    .overflow(overflow), .done(done)
  );

  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 capture, 2 drain, 3 done; queue holds buffered words.
  int          m_phase;
  logic [35:0] m_q[$];
  int          m_acc_cnt, m_pcount, m_addr;
  bit          m_ovf, m_we;
  logic [18:0] m_wa;
  logic [35:0] m_wd;

  bit          last_acc;
  int          dut_acc, done_seen, pt_idx;
  logic [9:0]  cur_x, cur_y, cur_z;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return (m_phase == 1) && (m_q.size() < DEPTH) && (m_acc_cnt < MAXP);
  endfunction

  task automatic check_all();
    chk("pt_ready", pt_ready, m_ready());
    chk("busy", busy, (m_phase == 1 || m_phase == 2));
    chk("done", done, (m_phase == 3));
    chk("write_en", write_en, m_we);
    chk("write_addr", write_addr, m_wa);
    chk("write_data", write_data, m_wd);
    chk("point_count", point_count, m_pcount[18:0]);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic model_reset();
    m_phase = 0; m_q.delete(); m_acc_cnt = 0; m_pcount = 0; m_addr = 0;
    m_ovf = 0; m_we = 0; m_wa = '0; m_wd = '0;
  endtask

  task automatic model_step(input bit rst, input bit fs, input bit fe, input bit pv,
                            input logic [9:0] x, input logic [9:0] y, input logic [9:0] z,
                            input bit slot);
    bit rdy, pop, we0;
    int qs0;
    if (rst) begin
      model_reset();
      return;
    end
    rdy = m_ready();
    qs0 = m_q.size();
    we0 = m_we;
    pop = (m_phase == 1 || m_phase == 2) && slot && (qs0 > 0);
    m_we = pop;
    if (pop) begin
      m_wd = m_q.pop_front();
      m_wa = m_addr[18:0];
      m_addr++;
      m_pcount++;
    end
    if (m_phase == 1 && pv && m_acc_cnt == MAXP) m_ovf = 1;
    if (pv && rdy) begin
      m_q.push_back({6'b0, x, y, z});
      m_acc_cnt++;
    end
    case (m_phase)
      0: if (fs) begin
           m_phase = 1; m_addr = BASE; m_pcount = 0; m_acc_cnt = 0; m_ovf = 0;
         end
      1: if (fe) m_phase = 2;
      2: if (qs0 == 0 && !we0) m_phase = 3;
      default: m_phase = 0;
    endcase
  endtask

  // One clock: check outputs, drive inputs, advance model, move to next negedge.
  task automatic cycle(input bit rst, input bit fs, input bit fe, input bit pv,
                       input logic [9:0] x, input logic [9:0] y, input logic [9:0] z,
                       input bit slot);
    check_all();
    if (done === 1'b1) done_seen++;
    reset = rst; frame_start = fs; frame_end = fe; pt_valid = pv;
    pt_x = x; pt_y = y; pt_z = z; wr_slot = slot;
    if (!rst && pv && pt_ready === 1'b1) dut_acc++;
    last_acc = !rst && pv && m_ready();
    model_step(rst, fs, fe, pv, x, y, z, slot);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic new_point();
    cur_x = 10'($urandom); cur_y = 10'($urandom); cur_z = 10'($urandom);
  endtask

  task automatic run_pts(input int ncyc, input int npts, input bit slot);
    for (int i = 0; i < ncyc; i++) begin
      cycle(0, 0, 0, (pt_idx < npts), cur_x, cur_y, cur_z, slot);
      if (last_acc) begin
        pt_idx++;
        new_point();
      end
    end
  endtask

  task automatic idle(input int n, input bit slot);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0, '0, '0, slot);
  endtask

  task automatic drain_to_idle();
    for (int i = 0; i < 60 && m_phase != 0; i++) cycle(0, 0, 0, 0, '0, '0, '0, 1);
    if (m_phase != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout phase=%0d required=0", m_phase);
    end
  endtask

  initial begin
    model_reset();
    new_point();
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state, then IDLE ignores offered points and slots.
    chk("rst_write_en", write_en, 0);
    chk("rst_busy", busy, 0);
    dut_acc = 0;
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, cur_x, cur_y, cur_z, 1);
    chk("idle_no_accept", dut_acc, 0);

    // Single point: write two cycles after acceptance.
    cycle(0, 1, 0, 0, '0, '0, '0, 0);
    cur_x = 10'd100; cur_y = 10'd100; cur_z = 10'd1020; pt_idx = 0;
    run_pts(2, 1, 1);
    chk("s2_write_en", write_en, 1);
    chk("s2_write_addr", write_addr, 19'd0);
    chk("s2_write_data", write_data, 36'h0064193FC);
    chk("s2_point_count", point_count, 19'd1);
    cycle(0, 0, 1, 0, '0, '0, '0, 1);
    drain_to_idle();

    // FIFO fills with slots withheld, then empties in order.
    cycle(0, 1, 0, 0, '0, '0, '0, 0);
    pt_idx = 0; dut_acc = 0;
    run_pts(10, 6, 0);
    chk("s3_accepts_full", dut_acc, 4);
    chk("s3_ready_low", pt_ready, 0);
    run_pts(12, 6, 1);
    chk("s3_accepts_total", dut_acc, 6);
    cycle(0, 0, 1, 0, '0, '0, '0, 1);
    drain_to_idle();
    chk("s3_point_count", point_count, 19'd6);

    // Capacity limit and overflow.
    cycle(0, 1, 0, 0, '0, '0, '0, 0);
    pt_idx = 0; dut_acc = 0;
    run_pts(16, 10, 1);
    chk("s4_ready_low", pt_ready, 0);
    cycle(0, 0, 1, 0, '0, '0, '0, 1);
    drain_to_idle();
    chk("s4_accepts", dut_acc, 8);
    chk("s4_overflow", overflow, 1);
    chk("s4_point_count", point_count, 19'd8);

    // Queue, end frame, drain; done pulses once; next frame clears status.
    cycle(0, 1, 0, 0, '0, '0, '0, 0);
    chk("s5_count_cleared", point_count, 19'd0);
    chk("s5_overflow_cleared", overflow, 0);
    pt_idx = 0;
    run_pts(3, 3, 0);
    cycle(0, 0, 1, 0, '0, '0, '0, 0);
    done_seen = 0;
    drain_to_idle();
    idle(3, 1);
    chk("s5_done_pulses", done_seen, 1);
    chk("s5_busy_low", busy, 0);
    chk("s5_point_count", point_count, 19'd3);

    // Reset while draining drops everything; next frame starts at BASE.
    cycle(0, 1, 0, 0, '0, '0, '0, 0);
    pt_idx = 0;
    run_pts(2, 2, 0);
    cycle(0, 0, 1, 0, '0, '0, '0, 0);
    chk("s6_in_drain", busy, 1);
    cycle(1, 0, 0, 0, '0, '0, '0, 1);
    chk("s6_we_after_reset", write_en, 0);
    chk("s6_busy_after_reset", busy, 0);
    idle(2, 1);
    cycle(0, 1, 0, 0, '0, '0, '0, 0);
    pt_idx = 0;
    run_pts(2, 1, 1);
    chk("s6_first_we", write_en, 1);
    chk("s6_first_addr", write_addr, 19'(BASE));
    cycle(0, 0, 1, 0, '0, '0, '0, 1);
    drain_to_idle();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 6),
            ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 60),
            10'($urandom), 10'($urandom), 10'($urandom), ($urandom_range(0, 1) == 1));
    end
    if (m_phase == 1) cycle(0, 0, 1, 0, '0, '0, '0, 1);
    drain_to_idle();
    idle(2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
